// File: rtl/rggen_mux_pipeline_pkg.sv
// Shared helpers for the read-data mux pipeline.
// Select legality is judged from the number of asserted select bits.
package rggen_mux_pipeline_pkg;

  function automatic logic select_error(input int ones, input logic check);
    return check && (ones != 1);
  endfunction

endpackage

// File: rtl/rggen_mux_pipeline_slice.sv
// Single valid/ready register slice; refills whenever empty or draining,
// so a bubble is collapsed even while the downstream side stalls.
module rggen_mux_pipeline_slice #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_payload,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_payload
);

  assign o_ready = !o_valid || i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_payload <= '0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      // payload holds across bubbles so nothing toggles without a beat
      if (i_valid) o_payload <= i_payload;
    end
  end

endmodule

// File: rtl/rggen_mux_pipeline.sv
// One-hot AND-OR read-data mux with select legality flag, followed by
// STAGES valid/ready register slices carrying {err, data}.
module rggen_mux_pipeline
  import rggen_mux_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ENTRIES      = 4,
  parameter int unsigned STAGES       = 1,
  parameter int unsigned CHECK_ONEHOT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [ENTRIES-1:0]         i_select,
  input  logic [WIDTH*ENTRIES-1:0]   i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_error
);

  localparam int unsigned PW = WIDTH + 1;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  // a single entry is a pass-through; select then only feeds the error flag
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      if (ENTRIES == 1 || i_select[j]) mux_data = mux_data | i_data[WIDTH*j +: WIDTH];
    end
  end

  assign mux_err = select_error($countones(i_select), CHECK_ONEHOT != 0);

  generate
    if (STAGES == 0) begin : g_comb
      assign o_valid = i_valid;
      assign o_ready = i_ready;
      assign o_data  = mux_data;
      assign o_error = mux_err;
    end else begin : g_pipe
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          in_valid;
        logic          in_ready;
        logic [PW-1:0] in_payload;
        logic          out_valid;
        logic          out_ready;
        logic [PW-1:0] out_payload;

        if (k == 0) begin : g_first
          assign in_valid   = i_valid;
          assign in_payload = {mux_err, mux_data};
        end else begin : g_mid
          assign in_valid   = g_stage[k-1].out_valid;
          assign in_payload = g_stage[k-1].out_payload;
        end

        if (k == STAGES - 1) begin : g_last
          assign out_ready = i_ready;
        end else begin : g_next
          assign out_ready = g_stage[k+1].in_ready;
        end

        rggen_mux_pipeline_slice #(
          .WIDTH (PW)
        ) u_slice (
          .i_clk     (i_clk),
          .i_rst_n   (i_rst_n),
          .i_valid   (in_valid),
          .o_ready   (in_ready),
          .i_payload (in_payload),
          .o_valid   (out_valid),
          .i_ready   (out_ready),
          .o_payload (out_payload)
        );
      end

      assign o_ready = g_stage[0].in_ready;
      assign o_valid = g_stage[STAGES-1].out_valid;
      assign o_data  = g_stage[STAGES-1].out_payload[WIDTH-1:0];
      assign o_error = g_stage[STAGES-1].out_payload[WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_rggen_mux_pipeline.sv
// Randomised and directed bench for rggen_mux_pipeline, checked against a
// queue model of in-flight beats plus a few literal expectations.
module tb_rggen_mux_pipeline;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the two 2-stage instances
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [3:0]  i_select = '0;
  logic [31:0] i_data = '0;

  logic       a_ready, a_valid, a_error;
  logic [7:0] a_data;
  logic       b_ready, b_valid, b_error;
  logic [7:0] b_data;

  logic       c_valid = 1'b0, c_ready = 1'b0;
  logic [0:0] c_sel = '0;
  logic [7:0] c_din = '0;
  logic       c_oready, c_ovalid, c_error;
  logic [7:0] c_data;

  rggen_mux_pipeline #(.WIDTH(8), .ENTRIES(4), .STAGES(S), .CHECK_ONEHOT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(a_ready),
    .i_select(i_select), .i_data(i_data), .o_valid(a_valid), .i_ready(i_ready),
    .o_data(a_data), .o_error(a_error));

  rggen_mux_pipeline #(.WIDTH(8), .ENTRIES(4), .STAGES(S), .CHECK_ONEHOT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready),
    .i_select(i_select), .i_data(i_data), .o_valid(b_valid), .i_ready(i_ready),
    .o_data(b_data), .o_error(b_error));

  rggen_mux_pipeline #(.WIDTH(8), .ENTRIES(1), .STAGES(0), .CHECK_ONEHOT(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .o_ready(c_oready),
    .i_select(c_sel), .i_data(c_din), .o_valid(c_ovalid), .i_ready(c_ready),
    .o_data(c_data), .o_error(c_error));

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         age;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int vld_cnt = 0;
  int rdy_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_data(input logic [3:0] sel, input logic [31:0] d);
    logic [7:0] r = 8'h00;
    for (int j = 0; j < 4; j++) if (sel[j]) r = r | d[8*j +: 8];
    return r;
  endfunction

  function automatic logic ref_err(input logic [3:0] sel);
    int n = 0;
    for (int j = 0; j < 4; j++) if (sel[j]) n++;
    return n != 1;
  endfunction

  // One clock: drive, compare every output against the model, advance the model.
  task automatic step(input logic v, input logic [3:0] sel, input logic [31:0] d, input logic rdy);
    logic exp_valid, exp_ready;
    beat_t nb;
    @(negedge clk);
    i_valid = v; i_select = sel; i_data = d; i_ready = rdy;
    c_valid = 1'($urandom); c_ready = 1'($urandom);
    c_sel = 1'($urandom); c_din = 8'($urandom);
    #1;
    exp_valid = (q.size() > 0) && (q[0].age >= S);
    exp_ready = (q.size() < S) || rdy;
    chk("a_valid", {31'd0, a_valid}, {31'd0, exp_valid});
    chk("a_ready", {31'd0, a_ready}, {31'd0, exp_ready});
    chk("b_valid", {31'd0, b_valid}, {31'd0, exp_valid});
    chk("b_ready", {31'd0, b_ready}, {31'd0, exp_ready});
    if (exp_valid) begin
      chk("a_data", {24'd0, a_data}, {24'd0, q[0].data});
      chk("a_error", {31'd0, a_error}, {31'd0, q[0].err});
      chk("b_data", {24'd0, b_data}, {24'd0, q[0].data});
      chk("b_error", {31'd0, b_error}, 32'd0);
    end
    chk("c_data", {24'd0, c_data}, {24'd0, c_din});
    chk("c_valid", {31'd0, c_ovalid}, {31'd0, c_valid});
    chk("c_ready", {31'd0, c_oready}, {31'd0, c_ready});
    chk("c_error", {31'd0, c_error}, {31'd0, c_sel == 1'b0});
    if (a_valid) vld_cnt++;
    if (!a_ready) rdy_drop++;
    if (exp_valid && rdy) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (v && exp_ready) begin
      nb.data = ref_data(sel, d);
      nb.err  = ref_err(sel);
      nb.age  = 1;
      q.push_back(nb);
      acc_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 32'h0, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 30) begin
      step(1'b0, 4'b0000, 32'h0, 1'b1);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic literal_beat(input logic [3:0] sel, input logic [7:0] ed, input logic ee);
    step(1'b1, sel, 32'h44332211, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("lit_not_yet_valid", {31'd0, a_valid}, 32'd0);
    step(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("lit_valid", {31'd0, a_valid}, 32'd1);
    chk("lit_data", {24'd0, a_data}, {24'd0, ed});
    chk("lit_error", {31'd0, a_error}, {31'd0, ee});
    chk("lit_error_nocheck", {31'd0, b_error}, 32'd0);
    chk("lit_data_nocheck", {24'd0, b_data}, {24'd0, ed});
  endtask

  initial begin
    logic [3:0] rs;
    #1;
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_data", {24'd0, a_data}, 32'd0);
    chk("rst_error", {31'd0, a_error}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single-entry combinational instance, pinned by hand
    c_sel = 1'b0; c_din = 8'hA5; c_valid = 1'b1; c_ready = 1'b0;
    #1;
    chk("c_lit_data", {24'd0, c_data}, 32'hA5);
    chk("c_lit_error", {31'd0, c_error}, 32'd1);
    chk("c_lit_valid_ready", {30'd0, c_ovalid, c_oready}, 32'd2);

    literal_beat(4'b0100, 8'h33, 1'b0);
    literal_beat(4'b0000, 8'h00, 1'b1);
    literal_beat(4'b0011, 8'h33, 1'b1);
    idle(2);

    // back-to-back stream
    vld_cnt = 0; rdy_drop = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0001 << (i % 4), $urandom, 1'b1);
    idle(4);
    chk("b2b_valid_cycles", vld_cnt, 8);
    chk("b2b_ready_drops", rdy_drop, 0);

    // stall: only S beats fit
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1000 >> (i % 4), $urandom, 1'b0);
    chk("stall_accepted", acc_cnt, S);
    chk("stall_ready_low", {31'd0, a_ready}, 32'd0);
    drain();

    // reset with two beats in flight
    step(1'b1, 4'b0010, 32'hDEADBEEF, 1'b0);
    step(1'b1, 4'b0100, 32'hCAFEF00D, 1'b0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, a_valid}, 32'd0);
    chk("midrst_data", {24'd0, a_data}, 32'd0);
    chk("midrst_error", {31'd0, a_error}, 32'd0);
    chk("midrst_ready", {31'd0, a_ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    idle(4);
    chk("midrst_no_stale", vld_cnt, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 6) rs = 4'b0001 << $urandom_range(0, 3);
      else rs = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, rs, $urandom, $urandom_range(0, 9) < 6);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
